xor_unit: RTL and testbench
===========================

Name: xor_unit

Overview:
- Registered, handshaked bitwise XOR stage: out = in1 ^ in2, one result per accepted input.
- Drop-in datapath primitive for the lab ALU/datapath; default WIDTH=1 behaves as a clocked 2-input XOR gate.
- Also produces registered side flags: parity of the result, and equality of the operands.

Parameters:
- WIDTH, 1, operand/result width in bits (legal range 1..64).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in1/in2 are valid this cycle
- in_ready  output  1  stage can accept an input this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- out_valid  output  1  out and flags hold a valid result
- out_ready  input  1  consumer accepts the result this cycle
- out  output  WIDTH  registered in1 ^ in2
- parity  output  1  registered reduction XOR of out (odd number of 1s)
- equal  output  1  registered (in1 == in2), i.e. out == 0

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async assert, released synchronously by the system):
  - out_valid=0, out=0, parity=0, equal=0.
- in_ready = !out_valid || out_ready. This is combinational, with no dependency on in_valid.
- Accept: in_valid && in_ready at a rising edge. On accept:
  - out <= in1 ^ in2 (bitwise).
  - parity <= ^(in1 ^ in2).
  - equal <= (in1 == in2).
  - out_valid <= 1.
- Latency: 1 cycle from accept to out_valid=1.
- Throughput: 1 result/cycle while out_ready=1.
- Drain: out_valid && out_ready && no accept -> out_valid <= 0. out, parity and equal keep their last values.
- Simultaneous drain and accept (out_valid=1, out_ready=1, in_valid=1): new result loaded, out_valid stays 1, no bubble.
- Stall: out_valid=1 && out_ready=0 -> in_ready=0. out, parity and equal are held stable. Inputs are ignored.
- Flags are only meaningful while out_valid=1.
- Reset mid-operation: any pending result is discarded and all outputs go to their reset values immediately (asynchronously).
- No X-propagation allowance: outputs must be 0/1 after reset, with no uninitialised state.

Decomposition:
- Shared package xor_pkg:
  - XOR_DEFAULT_WIDTH constant (=1).
  - Function xor_parity(vector) used by both RTL and bench model.
- Optional sub-module xor_pipe_reg: generic valid/ready single-entry register (data + flags). The XOR logic stays in xor_unit.

Test Plan:
- Reset: assert rst mid-cycle with out_valid=1 -> out_valid=0, out=0, parity=0, equal=0 without waiting for a clk edge.
- Truth table (WIDTH=1, out_ready=1): apply (in1,in2)=(0,0),(0,1),(1,0),(1,1), each held 100 ns with in_valid=1 -> out=0,1,1,0; equal=1,0,0,1; parity=out; each result appears one cycle after accept.
- Backpressure (WIDTH=8): accept 0xF0^0x0F, then out_ready=0 for 5 cycles while offering 0xAA^0x55 ->
  - out=0xFF, parity=0, equal=0 held for all 5 cycles, with in_ready=0.
  - Release out_ready -> next out=0xFF from the second pair, accepted exactly once.
- Streaming (WIDTH=8): in_valid and out_ready held at 1 for 16 consecutive random pairs -> 16 consecutive out_valid cycles, each out = in1^in2 from the previous cycle, and parity matches xor_pipe model.
- Bubble/drain: single accept of in1=in2=0x3C, then in_valid=0 -> out=0x00, equal=1, parity=0 for one cycle. out_valid then drops to 0, with out still holding 0x00.
- Width edge (WIDTH=64): in1=all-ones, in2=0 -> out=all-ones, parity=0 (64 ones), equal=0.

Source files
------------

// File: rtl/xor_pkg.sv
// Shared definitions for the registered XOR stage.
//   XOR_DEFAULT_WIDTH : default operand width (a clocked 2-input XOR gate)
//   XOR_MAX_WIDTH     : widest supported operand
//   slot_state_e      : occupancy of the single-entry output register
//   xor_flags_t       : side flags carried alongside the result
//   xor_parity()      : odd-ones detector, shared by the RTL and the bench model
package xor_pkg;

  localparam int unsigned XOR_DEFAULT_WIDTH = 1;
  localparam int unsigned XOR_MAX_WIDTH     = 64;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  typedef struct packed {
    logic equal;
    logic parity;
  } xor_flags_t;

  // Narrower vectors are zero-extended by the caller, which leaves parity unchanged.
  function automatic logic xor_parity(input logic [XOR_MAX_WIDTH-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/xor_if.sv
// Handshake bundle for the XOR stage.
//   in_valid/in_ready/in1/in2        : operand channel (producer -> stage)
//   out_valid/out_ready/out          : result channel (stage -> consumer)
//   parity/equal                     : registered flags travelling with out
// master : the side that drives operands and consumes results
// slave  : the XOR stage itself
interface xor_if
  import xor_pkg::*;
#(
  parameter int unsigned WIDTH = XOR_DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             parity;
  logic             equal;

  modport master (
    output in_valid, in1, in2, out_ready,
    input  in_ready, out_valid, out, parity, equal
  );

  modport slave (
    input  in_valid, in1, in2, out_ready,
    output in_ready, out_valid, out, parity, equal
  );

endinterface

// File: rtl/xor_pipe_reg.sv
// Generic single-entry valid/ready register.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : upstream handshake; in_ready = empty or draining
//   in_data              : payload captured on accept
//   out_valid/out_ready  : downstream handshake
//   out_data             : held payload; keeps its last value after a drain
module xor_pipe_reg
  import xor_pkg::*;
#(
  parameter int unsigned DW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  slot_state_e state;
  logic        load;

  assign in_ready  = (state == SLOT_EMPTY) || out_ready;
  assign load      = in_valid && in_ready;
  assign out_valid = (state == SLOT_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SLOT_EMPTY;
      out_data <= '0;
    end else if (load) begin
      // Covers both the empty case and drain-plus-refill in one edge.
      state    <= SLOT_FULL;
      out_data <= in_data;
    end else if (out_ready) begin
      state    <= SLOT_EMPTY;
    end
  end

endmodule

// File: rtl/xor_unit.sv
// Registered, handshaked bitwise XOR stage: out = in1 ^ in2, one result per
// accepted operand pair, one cycle of latency, full throughput.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears valid, result and flags)
//   bus  : xor_if slave port
//          in_valid/in_ready/in1/in2, out_valid/out_ready/out, parity, equal
//   parity : odd number of ones in out
//   equal  : operands were equal (out == 0)
module xor_unit
  import xor_pkg::*;
#(
  parameter int unsigned WIDTH = XOR_DEFAULT_WIDTH
) (
  input logic   clk,
  input logic   rst,
  xor_if.slave  bus
);

  localparam int unsigned DW = WIDTH + 2;

  logic [WIDTH-1:0]         res;
  logic [XOR_MAX_WIDTH-1:0] res_ext;
  xor_flags_t               flags_d;
  xor_flags_t               flags_q;
  logic [DW-1:0]            data_d;
  logic [DW-1:0]            data_q;

  always_comb begin
    res            = bus.in1 ^ bus.in2;
    res_ext        = '0;
    res_ext[WIDTH-1:0] = res;
    flags_d.parity = xor_parity(res_ext);
    flags_d.equal  = (bus.in1 == bus.in2);
  end

  assign data_d = {flags_d, res};

  xor_pipe_reg #(
    .DW (DW)
  ) u_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (data_d),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (data_q)
  );

  assign flags_q    = data_q[DW-1 -: 2];
  assign bus.out    = data_q[WIDTH-1:0];
  assign bus.parity = flags_q.parity;
  assign bus.equal  = flags_q.equal;

endmodule

// File: tb/tb_xor_unit.sv
// Scoreboard bench for xor_unit at WIDTH = 1, 8 and 64 (lanes 0, 1, 2).
module tb_xor_unit;
  import xor_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [2:0]       iv, ordy, ov, ir, par, eq;
  logic [2:0][63:0] a, b, o;
  int               ovcnt [3];
  logic [65:0]      q [3][$];

  xor_if #(.WIDTH(1))  b1  ();
  xor_if #(.WIDTH(8))  b8  ();
  xor_if #(.WIDTH(64)) b64 ();

  xor_unit #(.WIDTH(1))  u1  (.clk(clk), .rst(rst), .bus(b1.slave));
  xor_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8.slave));
  xor_unit #(.WIDTH(64)) u64 (.clk(clk), .rst(rst), .bus(b64.slave));

  assign b1.in_valid  = iv[0];  assign b1.out_ready  = ordy[0];
  assign b1.in1       = a[0][0:0]; assign b1.in2     = b[0][0:0];
  assign b8.in_valid  = iv[1];  assign b8.out_ready  = ordy[1];
  assign b8.in1       = a[1][7:0]; assign b8.in2     = b[1][7:0];
  assign b64.in_valid = iv[2];  assign b64.out_ready = ordy[2];
  assign b64.in1      = a[2];   assign b64.in2       = b[2];

  assign ov[0] = b1.out_valid;  assign ir[0] = b1.in_ready;
  assign o[0]  = {63'd0, b1.out}; assign par[0] = b1.parity; assign eq[0] = b1.equal;
  assign ov[1] = b8.out_valid;  assign ir[1] = b8.in_ready;
  assign o[1]  = {56'd0, b8.out}; assign par[1] = b8.parity; assign eq[1] = b8.equal;
  assign ov[2] = b64.out_valid; assign ir[2] = b64.in_ready;
  assign o[2]  = b64.out;       assign par[2] = b64.parity; assign eq[2] = b64.equal;

  task automatic chk(input string n, input int k, input logic [65:0] got, input logic [65:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s lane%0d got=%h expected=%h at %0t", n, k, got, exp, $time);
    end
  endtask

  function automatic int unsigned lane_w(input int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 64;
  endfunction

  // Expected {equal, parity, out} for an operand pair on a lane of width w.
  function automatic logic [65:0] expv(input logic [63:0] x, input logic [63:0] y, input int unsigned w);
    logic [63:0] m;
    logic [63:0] r;
    m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    r = (x ^ y) & m;
    return {(r == 64'd0), xor_parity(r), r};
  endfunction

  // Stimulus side: push the expected result whenever an accept happens.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) q[k].delete();
    end else begin
      for (int k = 0; k < 3; k++)
        if (iv[k] && (q[k].size() == 0 || ordy[k]))
          q[k].push_back(expv(a[k], b[k], lane_w(k)));
    end
  end

  // Monitor: compare presented outputs, pop what the next edge will drain.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        chk("out_valid", k, {65'd0, ov[k]}, {65'd0, (q[k].size() != 0)});
        chk("in_ready", k, {65'd0, ir[k]}, {65'd0, (q[k].size() == 0) || ordy[k]});
        if (ov[k] && q[k].size() != 0)
          chk("result", k, {eq[k], par[k], o[k]}, q[k][0]);
        if (q[k].size() != 0 && ordy[k]) void'(q[k].pop_front());
        if (ov[k]) ovcnt[k]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sa [16] = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h3C, 8'h80, 8'h7E, 8'h01,
                          8'hC3, 8'h55, 8'h99, 8'hF0, 8'h0F, 8'h66, 8'hE7, 8'h24};
  logic [7:0] sb [16] = '{8'h00, 8'h00, 8'h34, 8'hA5, 8'hC3, 8'h01, 8'h81, 8'hFE,
                          8'h3C, 8'hAA, 8'h66, 8'hF0, 8'h1F, 8'h99, 8'h18, 8'h42};
  logic       tt_o  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  logic       tt_eq [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int c0;
    iv = '0; ordy = '0; a = '0; b = '0;
    for (int k = 0; k < 3; k++) ovcnt[k] = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk("reset_state", k, {ov[k], eq[k], par[k], o[k]}, 66'd0);
    rst = 1'b0;

    // Shared parity helper against hand values
    chk("pkg_parity_ff", 0, {65'd0, xor_parity(64'hFF)}, 66'd0);
    chk("pkg_parity_07", 0, {65'd0, xor_parity(64'h7)}, 66'd1);
    chk("pkg_parity_msb", 0, {65'd0, xor_parity(64'h8000_0000_0000_0000)}, 66'd1);

    // Truth table, WIDTH=1, each pair held 100 ns
    ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a[0] = 64'(i >> 1); b[0] = 64'(i & 1); iv[0] = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      chk("tt_out", 0, {63'd0, ov[0], eq[0], o[0][0]}, {63'd0, 1'b1, tt_eq[i], tt_o[i]});
      chk("tt_parity", 0, {65'd0, par[0]}, {65'd0, tt_o[i]});
      #1;
    end
    step(); iv[0] = 1'b0;
    repeat (2) step();

    // Backpressure, WIDTH=8
    a[1] = 64'hF0; b[1] = 64'h0F; iv[1] = 1'b1; ordy[1] = 1'b1;
    step();
    a[1] = 64'hAA; b[1] = 64'h55; ordy[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", 1, {ov[1], eq[1], par[1], o[1]}, {1'b1, 1'b0, 1'b0, 64'hFF});
      chk("stall_in_ready", 1, {65'd0, ir[1]}, 66'd0);
    end
    step(); ordy[1] = 1'b1;
    step(); iv[1] = 1'b0;
    @(negedge clk);
    chk("bp_second", 1, {ov[1], eq[1], par[1], o[1]}, {1'b1, 1'b0, 1'b0, 64'hFF});
    @(negedge clk);
    chk("bp_once", 1, {65'd0, ov[1]}, 66'd0);
    repeat (2) step();

    // Streaming, WIDTH=8, 16 back-to-back pairs
    c0 = ovcnt[1];
    for (int i = 0; i < 16; i++) begin
      a[1] = {56'd0, sa[i]}; b[1] = {56'd0, sb[i]}; iv[1] = 1'b1;
      step();
    end
    iv[1] = 1'b0;
    repeat (3) step();
    chk("stream_count", 1, 66'(ovcnt[1] - c0), 66'd16);

    // Bubble / drain, WIDTH=8
    a[1] = 64'h3C; b[1] = 64'h3C; iv[1] = 1'b1;
    step(); iv[1] = 1'b0;
    @(negedge clk);
    chk("bubble_valid", 1, {ov[1], eq[1], par[1], o[1]}, {1'b1, 1'b1, 1'b0, 64'h0});
    @(negedge clk);
    chk("bubble_drained", 1, {ov[1], eq[1], par[1], o[1]}, {1'b0, 1'b1, 1'b0, 64'h0});
    #1;
    repeat (2) step();

    // Width edge, WIDTH=64
    a[2] = '1; b[2] = '0; iv[2] = 1'b1; ordy[2] = 1'b1;
    step(); iv[2] = 1'b0;
    @(negedge clk);
    chk("w64_ones", 2, {ov[2], eq[2], par[2], o[2]}, {1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF});
    #1;
    repeat (2) step();

    // Asynchronous reset while a result is held
    a[2] = 64'h5; b[2] = 64'h0; iv[2] = 1'b1; ordy[2] = 1'b0;
    step(); iv[2] = 1'b0;
    #2;
    chk("pre_reset_valid", 2, {ov[2], eq[2], par[2], o[2]}, {1'b1, 1'b0, 1'b0, 64'h5});
    rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++)
      chk("async_reset", k, {ov[k], eq[k], par[k], o[k]}, 66'd0);
    step(); rst = 1'b0; ordy[2] = 1'b1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
